// File: rtl/kgp_fsm_control_unit_pkg.sv
// KGP-RISC ISA definitions shared by the multi-cycle control unit:
// FSM states, opcode classes, ALU/branch operation codes and the control word.
package kgp_isa_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CODE_W = 4;

  localparam logic [2:0] OPC_ALU   = 3'd0;
  localparam logic [2:0] OPC_ALUI  = 3'd1;
  localparam logic [2:0] OPC_MEM   = 3'd2;
  localparam logic [2:0] OPC_BR    = 3'd3;
  localparam logic [2:0] OPC_BRR   = 3'd4;
  localparam logic [2:0] OPC_BCOND = 3'd5;

  localparam logic [CODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [CODE_W-1:0] ALU_COMP = 4'd1;
  localparam logic [CODE_W-1:0] ALU_XOR  = 4'd2;
  localparam logic [CODE_W-1:0] ALU_AND  = 4'd3;
  localparam logic [CODE_W-1:0] ALU_SHLL = 4'd4;
  localparam logic [CODE_W-1:0] ALU_SHRL = 4'd5;
  localparam logic [CODE_W-1:0] ALU_SHRA = 4'd6;
  localparam logic [CODE_W-1:0] ALU_NCHK = 4'd7;
  localparam logic [CODE_W-1:0] ALU_ZCHK = 4'd8;

  localparam logic [CODE_W-1:0] BR_B    = 4'd1;
  localparam logic [CODE_W-1:0] BR_BL   = 4'd2;
  localparam logic [CODE_W-1:0] BR_BCY  = 4'd3;
  localparam logic [CODE_W-1:0] BR_BNCY = 4'd4;
  localparam logic [CODE_W-1:0] BR_BR   = 4'd5;
  localparam logic [CODE_W-1:0] BR_BLTZ = 4'd6;
  localparam logic [CODE_W-1:0] BR_BZ   = 4'd7;
  localparam logic [CODE_W-1:0] BR_BNZ  = 4'd8;

  typedef struct packed {
    logic              mem_to_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              reg_write;
    logic              is_mem;
    logic              is_branch;
    logic [CODE_W-1:0] alu_op;
    logic [CODE_W-1:0] branch_op;
    logic              legal;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NOP = '0;

endpackage

// File: rtl/kgp_fsm_control_unit_if.sv
// Control-unit bus: instruction fields and memory handshakes in, datapath
// control out. The control unit is the master; datapath/memory is the slave.
interface kgp_fsm_control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int FUNC_W   = 4,
  parameter int ALUOP_W  = 4,
  parameter int BROP_W   = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   funccode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                ir_load;
  logic                dmem_req;
  logic                mem_write;
  logic                mem_to_read;
  logic                mem_to_reg;
  logic                reg_write;
  logic                pc_write;
  logic [ALUOP_W-1:0]  alu_op;
  logic [BROP_W-1:0]   branch_op;
  logic                illegal_instr;
  logic [2:0]          state_o;

  modport master (
    input  opcode, funccode, imem_ready, dmem_ready,
    output imem_req, ir_load, dmem_req, mem_write, mem_to_read, mem_to_reg,
           reg_write, pc_write, alu_op, branch_op, illegal_instr, state_o
  );

  modport slave (
    output opcode, funccode, imem_ready, dmem_ready,
    input  imem_req, ir_load, dmem_req, mem_write, mem_to_read, mem_to_reg,
           reg_write, pc_write, alu_op, branch_op, illegal_instr, state_o
  );
endinterface

// File: rtl/kgp_fsm_control_unit_decode_rom.sv
// Combinational instruction classifier: {opcode, funccode} -> control word.
// Unmapped encodings return an all-zero word with legal=0.
module kgp_decode_rom
  import kgp_isa_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int FUNC_W   = 4
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FUNC_W-1:0]   i_funccode,
  output ctrl_word_t          o_cw
);

  logic [2:0] w_op;
  logic [3:0] w_fn;
  logic       w_upper_zero;
  ctrl_word_t w_cw;

  assign w_op         = i_opcode[2:0];
  assign w_fn         = i_funccode[3:0];
  assign w_upper_zero = ((i_opcode >> 3) == '0) && ((i_funccode >> 4) == '0);

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    w_cw = CW_NOP;
    case (w_op)
      OPC_ALU: begin
        w_cw.mem_to_reg = 1'b1;
        w_cw.reg_write  = 1'b1;
        w_cw.legal      = (w_fn <= 4'd6);
        case (w_fn)
          4'd2:    w_cw.alu_op = ALU_AND;
          4'd3:    w_cw.alu_op = ALU_XOR;
          default: w_cw.alu_op = w_fn;
        endcase
      end
      OPC_ALUI: begin
        w_cw.mem_to_read = 1'b1;
        w_cw.mem_to_reg  = 1'b1;
        w_cw.reg_write   = 1'b1;
        w_cw.legal       = (w_fn >= 4'd1) && (w_fn <= 4'd5);
        case (w_fn)
          4'd2:    w_cw.alu_op = ALU_COMP;
          4'd3:    w_cw.alu_op = ALU_SHLL;
          4'd4:    w_cw.alu_op = ALU_SHRL;
          4'd5:    w_cw.alu_op = ALU_SHRA;
          default: w_cw.alu_op = ALU_ADD;
        endcase
      end
      OPC_MEM: begin
        w_cw.is_mem      = 1'b1;
        w_cw.mem_to_read = 1'b1;
        w_cw.legal       = (w_fn <= 4'd1);
        if (w_fn == 4'd0) w_cw.reg_write = 1'b1;
        else              w_cw.mem_write = 1'b1;
      end
      OPC_BR: begin
        w_cw.is_branch = 1'b1;
        w_cw.legal     = (w_fn <= 4'd3);
        w_cw.branch_op = w_fn + BR_B;
      end
      OPC_BRR: begin
        w_cw.is_branch = 1'b1;
        w_cw.legal     = (w_fn == 4'd0);
        w_cw.branch_op = BR_BR;
      end
      OPC_BCOND: begin
        w_cw.is_branch = 1'b1;
        w_cw.legal     = (w_fn <= 4'd2);
        case (w_fn)
          4'd0: begin
            w_cw.branch_op = BR_BLTZ;
            w_cw.alu_op    = ALU_NCHK;
          end
          4'd1: begin
            w_cw.branch_op = BR_BZ;
            w_cw.alu_op    = ALU_ZCHK;
          end
          default: begin
            w_cw.branch_op = BR_BNZ;
            w_cw.alu_op    = ALU_ZCHK;
          end
        endcase
      end
      default: w_cw = CW_NOP;
    endcase
    // Illegal encodings must not leak partial control fields.
    if (!(w_cw.legal && w_upper_zero)) w_cw = CW_NOP;
  end

  assign o_cw = w_cw;

endmodule

// File: rtl/kgp_fsm_control_unit.sv
// Multi-cycle KGP-RISC control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with
// registered control outputs computed from the next state.
module kgp_fsm_control_unit
  import kgp_isa_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int FUNC_W      = 4,
  parameter int ALUOP_W     = 4,
  parameter int BROP_W      = 4,
  parameter bit TRAP_RESUME = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  kgp_fsm_control_unit_if.master bus
);

  state_t              r_state, w_next;
  logic [OPCODE_W-1:0] r_ir_op;
  logic [FUNC_W-1:0]   r_ir_fn;
  ctrl_word_t          r_cw, w_rom_cw, w_cw;

  logic               r_imem_req, r_dmem_req, r_mem_write, r_mem_to_read, r_mem_to_reg;
  logic               r_reg_write, r_pc_write, r_illegal;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [BROP_W-1:0]  r_branch_op;

  logic               w_ir_load, w_in_body;
  logic               w_imem_req, w_dmem_req, w_mem_write, w_mem_to_read, w_mem_to_reg;
  logic               w_reg_write, w_pc_write, w_illegal;
  logic [ALUOP_W-1:0] w_alu_op;
  logic [BROP_W-1:0]  w_branch_op;

  kgp_decode_rom #(.OPCODE_W(OPCODE_W), .FUNC_W(FUNC_W)) u_decode_rom (
    .i_opcode   (r_ir_op),
    .i_funccode (r_ir_fn),
    .o_cw       (w_rom_cw)
  );

  // A ready only counts while the matching request is actually up.
  assign w_ir_load = r_imem_req & bus.imem_ready;
  assign w_cw      = (r_state == S_DECODE) ? w_rom_cw : r_cw;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_ir_load) w_next = S_DECODE;
      S_DECODE: w_next = w_rom_cw.legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (r_cw.is_mem)         w_next = S_MEM;
        else if (r_cw.reg_write) w_next = S_WB;
        else                     w_next = S_FETCH;
      end
      S_MEM:    if (r_dmem_req && bus.dmem_ready) w_next = r_cw.reg_write ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   if (TRAP_RESUME) w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase

    w_in_body     = (w_next == S_EXEC) || (w_next == S_MEM) || (w_next == S_WB);
    w_imem_req    = (w_next == S_FETCH);
    w_dmem_req    = (w_next == S_MEM);
    w_mem_write   = (w_next == S_MEM) && w_cw.mem_write;
    w_mem_to_read = w_in_body && w_cw.mem_to_read;
    w_mem_to_reg  = w_in_body && w_cw.mem_to_reg;
    w_alu_op      = w_in_body ? ALUOP_W'(w_cw.alu_op) : '0;
    w_reg_write   = (w_next == S_WB);
    w_pc_write    = (w_next == S_EXEC) && w_cw.is_branch;
    w_branch_op   = (w_next == S_EXEC) ? BROP_W'(w_cw.branch_op) : '0;
    w_illegal     = (w_next == S_TRAP);
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_imem_req    <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_read <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_reg_write   <= 1'b0;
      r_pc_write    <= 1'b0;
      r_illegal     <= 1'b0;
      r_alu_op      <= '0;
      r_branch_op   <= '0;
    end else begin
      r_state       <= w_next;
      r_imem_req    <= w_imem_req;
      r_dmem_req    <= w_dmem_req;
      r_mem_write   <= w_mem_write;
      r_mem_to_read <= w_mem_to_read;
      r_mem_to_reg  <= w_mem_to_reg;
      r_reg_write   <= w_reg_write;
      r_pc_write    <= w_pc_write;
      r_illegal     <= w_illegal;
      r_alu_op      <= w_alu_op;
      r_branch_op   <= w_branch_op;
    end
  end

  // NOTE: IR and control word are data registers, but they are reset anyway
  // so DECODE never classifies an x pattern and every output stays known.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir_op <= '0;
      r_ir_fn <= '0;
      r_cw    <= CW_NOP;
    end else begin
      if (w_ir_load) begin
        r_ir_op <= bus.opcode;
        r_ir_fn <= bus.funccode;
      end
      if (r_state == S_DECODE) r_cw <= w_rom_cw;
    end
  end

  assign bus.imem_req      = r_imem_req;
  assign bus.ir_load       = w_ir_load;
  assign bus.dmem_req      = r_dmem_req;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_to_read   = r_mem_to_read;
  assign bus.mem_to_reg    = r_mem_to_reg;
  assign bus.reg_write     = r_reg_write;
  assign bus.pc_write      = r_pc_write;
  assign bus.alu_op        = r_alu_op;
  assign bus.branch_op     = r_branch_op;
  assign bus.illegal_instr = r_illegal;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_kgp_fsm_control_unit.sv
// Directed bench for kgp_fsm_control_unit: two instances (sticky trap and
// resuming trap) driven cycle by cycle against hand-computed output vectors.
module tb_kgp_fsm_control_unit;

  // flags = {imem_req, ir_load, dmem_req, mem_write, mem_to_read,
  //          mem_to_reg, reg_write, pc_write, illegal_instr}
  typedef struct packed {
    logic [2:0] st;
    logic [8:0] flags;
    logic [3:0] alu;
    logic [3:0] br;
  } out_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  kgp_fsm_control_unit_if #(.OPCODE_W(3), .FUNC_W(4), .ALUOP_W(4), .BROP_W(4)) bus0 ();
  kgp_fsm_control_unit_if #(.OPCODE_W(3), .FUNC_W(4), .ALUOP_W(4), .BROP_W(4)) bus1 ();

  kgp_fsm_control_unit #(
    .OPCODE_W(3), .FUNC_W(4), .ALUOP_W(4), .BROP_W(4), .TRAP_RESUME(1'b0)
  ) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  kgp_fsm_control_unit #(
    .OPCODE_W(3), .FUNC_W(4), .ALUOP_W(4), .BROP_W(4), .TRAP_RESUME(1'b1)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] st, input logic [8:0] flags,
                              input logic [3:0] alu, input logic [3:0] br);
    out_t o;
    o.st = st; o.flags = flags; o.alu = alu; o.br = br;
    return o;
  endfunction

  function automatic out_t obs0();
    return {bus0.state_o, bus0.imem_req, bus0.ir_load, bus0.dmem_req, bus0.mem_write,
            bus0.mem_to_read, bus0.mem_to_reg, bus0.reg_write, bus0.pc_write,
            bus0.illegal_instr, bus0.alu_op, bus0.branch_op};
  endfunction

  function automatic out_t obs1();
    return {bus1.state_o, bus1.imem_req, bus1.ir_load, bus1.dmem_req, bus1.mem_write,
            bus1.mem_to_read, bus1.mem_to_reg, bus1.reg_write, bus1.pc_write,
            bus1.illegal_instr, bus1.alu_op, bus1.branch_op};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    out_t idle;
    idle = mk(3'd0, 9'b100000000, 4'd0, 4'd0);
    reset = 1'b0;
    bus0.opcode = '0; bus0.funccode = '0; bus0.imem_ready = 1'b0; bus0.dmem_ready = 1'b0;
    bus1.opcode = '0; bus1.funccode = '0; bus1.imem_ready = 1'b0; bus1.dmem_ready = 1'b0;
    #1;
    if (obs0() !== out_t'(0)) begin
      $display("FAIL reset_async got=%h expected=%h", obs0(), out_t'(0)); failures++;
    end
    checks++;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    if (obs0() !== out_t'(0)) begin
      $display("FAIL reset_release_pre_edge got=%h expected=%h", obs0(), out_t'(0)); failures++;
    end
    checks++;
    step();
    if (obs0() !== idle) begin
      $display("FAIL reset_first_edge got=%h expected=%h", obs0(), idle); failures++;
    end
    checks++;
    if (obs1() !== idle) begin
      $display("FAIL reset_first_edge_dut1 got=%h expected=%h", obs1(), idle); failures++;
    end
    checks++;
  endtask

  task automatic test_add();
    out_t exp_v [5];
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd2, 9'b000001000, 4'd0, 4'd0), mk(3'd4, 9'b000001100, 4'd0, 4'd0),
              mk(3'd0, 9'b100000000, 4'd0, 4'd0)};
    bus0.opcode = 3'd0; bus0.funccode = 4'd0;
    for (int c = 0; c < 5; c++) begin
      bus0.imem_ready = (c < 4);
      bus0.dmem_ready = 1'b1;
      #1;
      if (obs0() !== exp_v[c]) begin
        $display("FAIL add cycle=%0d got=%h expected=%h", c, obs0(), exp_v[c]); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_lw_wait();
    out_t exp_v [9];
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd2, 9'b000010000, 4'd0, 4'd0), mk(3'd3, 9'b001010000, 4'd0, 4'd0),
              mk(3'd3, 9'b001010000, 4'd0, 4'd0), mk(3'd3, 9'b001010000, 4'd0, 4'd0),
              mk(3'd3, 9'b001010000, 4'd0, 4'd0), mk(3'd4, 9'b000010100, 4'd0, 4'd0),
              mk(3'd0, 9'b100000000, 4'd0, 4'd0)};
    bus0.opcode = 3'd2; bus0.funccode = 4'd0;
    for (int c = 0; c < 9; c++) begin
      bus0.imem_ready = (c == 0);
      bus0.dmem_ready = (c == 6);
      #1;
      if (obs0() !== exp_v[c]) begin
        $display("FAIL lw_wait cycle=%0d got=%h expected=%h", c, obs0(), exp_v[c]); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_bnz();
    out_t exp_v [4];
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd2, 9'b000000010, 4'd8, 4'd8), mk(3'd0, 9'b100000000, 4'd0, 4'd0)};
    bus0.opcode = 3'd5; bus0.funccode = 4'd2;
    for (int c = 0; c < 4; c++) begin
      bus0.imem_ready = (c == 0);
      bus0.dmem_ready = 1'b0;
      #1;
      if (obs0() !== exp_v[c]) begin
        $display("FAIL bnz cycle=%0d got=%h expected=%h", c, obs0(), exp_v[c]); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_xor_hold();
    out_t exp_v [5];
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd2, 9'b000001000, 4'd2, 4'd0), mk(3'd4, 9'b000001100, 4'd2, 4'd0),
              mk(3'd0, 9'b100000000, 4'd0, 4'd0)};
    for (int c = 0; c < 5; c++) begin
      // Fields change after the ir_load cycle and must be ignored.
      bus0.opcode   = (c == 0) ? 3'd0 : (c == 1) ? 3'd5 : 3'd7;
      bus0.funccode = (c == 0) ? 4'd3 : (c == 1) ? 4'd2 : 4'd15;
      bus0.imem_ready = (c < 4);
      bus0.dmem_ready = 1'b0;
      #1;
      if (obs0() !== exp_v[c]) begin
        $display("FAIL xor_hold cycle=%0d got=%h expected=%h", c, obs0(), exp_v[c]); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_sw();
    out_t exp_v [5];
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd2, 9'b000010000, 4'd0, 4'd0), mk(3'd3, 9'b001110000, 4'd0, 4'd0),
              mk(3'd0, 9'b100000000, 4'd0, 4'd0)};
    bus0.opcode = 3'd2; bus0.funccode = 4'd1;
    for (int c = 0; c < 5; c++) begin
      bus0.imem_ready = (c == 0);
      bus0.dmem_ready = 1'b1;
      #1;
      if (obs0() !== exp_v[c]) begin
        $display("FAIL sw cycle=%0d got=%h expected=%h", c, obs0(), exp_v[c]); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_reset_mid_mem();
    out_t exp_v [4];
    out_t idle;
    idle  = mk(3'd0, 9'b100000000, 4'd0, 4'd0);
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd2, 9'b000010000, 4'd0, 4'd0), mk(3'd3, 9'b001110000, 4'd0, 4'd0)};
    bus0.opcode = 3'd2; bus0.funccode = 4'd1;
    for (int c = 0; c < 4; c++) begin
      bus0.imem_ready = (c == 0);
      bus0.dmem_ready = 1'b0;
      #1;
      if (obs0() !== exp_v[c]) begin
        $display("FAIL sw_pre_reset cycle=%0d got=%h expected=%h", c, obs0(), exp_v[c]); failures++;
      end
      checks++;
      if (c < 3) step();
    end
    #1;
    reset = 1'b0;
    #1;
    if (obs0() !== out_t'(0)) begin
      $display("FAIL reset_mid_mem got=%h expected=%h", obs0(), out_t'(0)); failures++;
    end
    checks++;
    #2;
    reset = 1'b1;
    step();
    if (obs0() !== idle) begin
      $display("FAIL reset_mid_mem_restart got=%h expected=%h", obs0(), idle); failures++;
    end
    checks++;
  endtask

  task automatic test_trap_sticky();
    out_t e;
    bus0.opcode = 3'd0; bus0.funccode = 4'd7;
    for (int c = 0; c < 23; c++) begin
      bus0.imem_ready = 1'b1;
      bus0.dmem_ready = 1'b1;
      e = (c == 0) ? mk(3'd0, 9'b110000000, 4'd0, 4'd0) :
          (c == 1) ? mk(3'd1, 9'b000000000, 4'd0, 4'd0) :
                     mk(3'd5, 9'b000000001, 4'd0, 4'd0);
      #1;
      if (obs0() !== e) begin
        $display("FAIL trap_sticky cycle=%0d got=%h expected=%h", c, obs0(), e); failures++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_trap_resume();
    out_t exp_v [8];
    exp_v = '{mk(3'd0, 9'b110000000, 4'd0, 4'd0), mk(3'd1, 9'b000000000, 4'd0, 4'd0),
              mk(3'd5, 9'b000000001, 4'd0, 4'd0), mk(3'd0, 9'b110000000, 4'd0, 4'd0),
              mk(3'd1, 9'b000000000, 4'd0, 4'd0), mk(3'd2, 9'b000011000, 4'd4, 4'd0),
              mk(3'd4, 9'b000011100, 4'd4, 4'd0), mk(3'd0, 9'b100000000, 4'd0, 4'd0)};
    for (int c = 0; c < 8; c++) begin
      bus1.opcode     = (c < 3) ? 3'd0 : 3'd1;
      bus1.funccode   = (c < 3) ? 4'd7 : 4'd3;
      bus1.imem_ready = (c == 0) || (c == 3);
      bus1.dmem_ready = 1'b0;
      #1;
      if (obs1() !== exp_v[c]) begin
        $display("FAIL trap_resume cycle=%0d got=%h expected=%h", c, obs1(), exp_v[c]); failures++;
      end
      checks++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    #2;
    test_reset();
    test_add();
    test_lw_wait();
    test_bnz();
    test_xor_hold();
    test_sw();
    test_reset_mid_mem();
    test_trap_sticky();
    test_reset();
    test_trap_resume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kgp_fsm_control_unit.md
# kgp_fsm_control_unit

Multi-cycle, parametrised control unit for the KGP-RISC datapath. It replaces the purely combinational opcode/function decode with a registered FSM that sequences FETCH, DECODE, EXEC, MEM and WB. It handshakes with instruction and data memory, flags illegal encodings, and drives the same ALU-op and branch-op encodings the datapath already uses.

## Interface
- OPCODE_W, 3, opcode field width (≥3)
- FUNC_W, 4, function field width (≥4)
- ALUOP_W, 4, ALU-op output width (≥4)
- BROP_W, 4, branch-op output width (≥4)
- TRAP_RESUME, 0, 0: illegal_instr is sticky in TRAP; 1: one-cycle pulse, then FETCH
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  opcode field of the fetched word, valid when ir_load is high
- funccode  in  FUNC_W  function field, valid when ir_load is high
- imem_ready  in  1  instruction word available
- dmem_ready  in  1  data access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  latch IR and increment PC (one-cycle pulse)
- dmem_req  out  1  data-memory request
- mem_write  out  1  store qualifier for dmem_req
- mem_to_read  out  1  ALU B source: 1 = immediate, 0 = register
- mem_to_reg  out  1  writeback source: 1 = ALU, 0 = memory
- reg_write  out  1  register-file write (one-cycle pulse in WB)
- pc_write  out  1  branch PC load (one-cycle pulse in EXEC)
- alu_op  out  ALUOP_W  ALU operation
- branch_op  out  BROP_W  branch type
- illegal_instr  out  1  unmapped encoding seen
- state_o  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - imem_req=1 until imem_ready is sampled high.
  - That same cycle: ir_load=1, latch {opcode, funccode} into an internal register, go to DECODE.
- DECODE: classify the latched code and register the control word.
- Decode map (all values are ALU-op / branch-op codes):
  - Opcode 0 (ALU register; mem_to_read=0, mem_to_reg=1): func 0 add→0, func 1 comp→1, func 2 and→3, func 3 xor→2, func 4 shllv→4, func 5 shrlv→5, func 6 shrav→6.
  - Opcode 1 (ALU immediate; mem_to_read=1, mem_to_reg=1): func 1 addi→0, func 2 compi→1, func 3 shll→4, func 4 shrl→5, func 5 shra→6.
  - Opcode 2 (memory; alu_op=0, mem_to_read=1): func 0 lw (mem_to_reg=0), func 1 sw.
  - Opcode 3 (unconditional branch): func 0..3 give branch_op 1..4.
  - Opcode 4: func 0 br, branch_op 5.
  - Opcode 5 (conditional branch): func 0 bltz (branch_op 6, alu_op 7), func 1 bz (branch_op 7, alu_op 8), func 2 bnz (branch_op 8, alu_op 8).
- Any other code, including nonzero bits above bit 2 of opcode or bit 3 of funccode, goes to TRAP.
- Sequences:
  - ALU: DECODE→EXEC→WB→FETCH.
  - lw: EXEC→MEM→WB→FETCH.
  - sw: EXEC→MEM→FETCH.
  - Branch: EXEC (pc_write=1, branch_op valid)→FETCH. The datapath evaluates the condition, so pc_write is asserted for taken and untaken branches alike.
- MEM:
  - dmem_req=1, with mem_write=1 for sw only.
  - Stay in MEM until dmem_ready is sampled high; mem_write is stable throughout.
- WB: reg_write=1 for exactly one cycle.
- TRAP:
  - TRAP_RESUME=0: illegal_instr=1 and the FSM stays in TRAP until reset.
  - TRAP_RESUME=1: illegal_instr=1 for one cycle, then FETCH.
  - In either mode there are no writes and no requests.
- Every output is driven to a known value. Fields that do not matter for an instruction are driven to 0, never x.

## Timing
- Reset (low):
  - State goes to FETCH and all outputs to 0 asynchronously.
  - imem_req rises in the first cycle after reset deasserts.
- Assertion of reset mid-operation aborts the instruction immediately; dmem_req, reg_write and pc_write drop the same instant.
- Control outputs are registered from state plus the latched code. alu_op, mem_to_read and mem_to_reg are held from EXEC through the last cycle of the instruction.
- Zero-wait latency (FETCH to next FETCH):
  - ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle on imem_ready or dmem_ready adds one cycle.
- opcode and funccode are sampled only on the ir_load cycle; later changes are ignored.
- A ready signal seen while the matching req is low is ignored.

## Structure
- Package kgp_isa_pkg holds:
  - state enum;
  - opcode class constants;
  - ALU-op constants ADD..ZCHK;
  - branch-op constants B..BNZ;
  - the control-word struct {mem_to_read, mem_to_reg, mem_write, reg_write, is_mem, is_branch, alu_op, branch_op, legal}.
- Sub-module kgp_decode_rom: combinational {opcode, funccode} → control word. The FSM registers its output in DECODE.

## Test plan
- Reset low mid-MEM of sw, with dmem_req=1 → all outputs 0 at once; after release, imem_req=1 on the first edge and state_o=0.
- add (0,0) with imem_ready and dmem_ready tied high → ir_load at cycle 0, alu_op=0 and mem_to_reg=1 in EXEC, reg_write pulse at cycle 3, imem_req again at cycle 4.
- lw (2,0) with dmem_ready delayed 3 cycles → dmem_req held 4 cycles with mem_write=0, mem_to_reg=0, then a single reg_write pulse.
- bnz (5,2) → pc_write=1, branch_op=8, alu_op=8 for one cycle in EXEC; reg_write never asserted; back to FETCH after 3 cycles.
- Illegal (0,7):
  - TRAP_RESUME=0 → illegal_instr stays 1 and imem_req stays 0 for 20 cycles.
  - TRAP_RESUME=1 → a one-cycle pulse, then a fetch.
- opcode and funccode changed during DECODE/EXEC of xor (0,3) → alu_op stays 2 throughout.
